// File: rtl/tmr_capture.sv
// rtl/tmr_capture.sv - timer input capture: pin synchronizer, edge detect and capture FIFO
module tmr_capture_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DW-1:0]            m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign pop      = m_tready && !empty;
    // A slot freed by a same-cycle pop can take the incoming entry even when full.
    assign s_tready = !full || pop;
    assign push     = s_tvalid && s_tready;

    assign m_tvalid = !empty;
    assign m_tdata  = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign count    = wr_q - rd_q;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= s_tdata;
        end
    end
endmodule

module tmr_capture #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              TMR,
    input  logic                     CAPIN,
    input  logic                     CAPEN,
    input  logic [1:0]               CAPEDGE,
    input  logic                     CAPRD,
    input  logic                     CAPOVFCLR,
    output logic [31:0]              CAPVAL,
    output logic                     CAPVALID,
    output logic [$clog2(DEPTH):0]   CAPCNT,
    output logic                     CAPOVF
);
    localparam int WW = $clog2(SYNC_STAGES + 2);
    localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WW-1:0]          warm_q, warm_d;
    logic                   ovf_q, ovf_d;

    logic s;
    logic warm_done;
    logic rise;
    logic fall;
    logic cap_event;
    logic fifo_ready;
    logic drop;

    assign s         = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_q == WARM_DONE);
    assign rise      = s && !hist_q;
    assign fall      = !s && hist_q;
    assign cap_event = CAPEN && warm_done && ((CAPEDGE[0] && rise) || (CAPEDGE[1] && fall));
    assign drop      = cap_event && !fifo_ready;

    always_comb begin
        // Pin pipeline runs regardless of CAPEN so enabling never sees a stale edge.
        sync_d = {sync_q[SYNC_STAGES-2:0], CAPIN};
        hist_d = s;
        warm_d = warm_done ? warm_q : warm_q + WW'(1);
        ovf_d  = ovf_q;
        if (CAPOVFCLR) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            warm_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            warm_q <= warm_d;
            ovf_q  <= ovf_d;
        end
    end

    tmr_capture_fifo #(
        .DW    (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (TMR),
        .s_tvalid (cap_event),
        .s_tready (fifo_ready),
        .m_tdata  (CAPVAL),
        .m_tvalid (CAPVALID),
        .m_tready (CAPRD),
        .count    (CAPCNT)
    );

    assign CAPOVF = ovf_q;
endmodule

// File: tb/tb_tmr_capture.sv
// tb/tb_tmr_capture.sv - directed self-checking bench for tmr_capture
module tb_tmr_capture;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tmr;
    logic        capin;
    logic        capen;
    logic [1:0]  capedge;
    logic        caprd;
    logic        capovfclr;
    logic [31:0] capval;
    logic        capvalid;
    logic [2:0]  capcnt;
    logic        capovf;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_v [0:7];

    tmr_capture #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .TMR       (tmr),
        .CAPIN     (capin),
        .CAPEN     (capen),
        .CAPEDGE   (capedge),
        .CAPRD     (caprd),
        .CAPOVFCLR (capovfclr),
        .CAPVAL    (capval),
        .CAPVALID  (capvalid),
        .CAPCNT    (capcnt),
        .CAPOVF    (capovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        tmr = tmr + 32'd1;
    endtask

    task automatic pop();
        caprd = 1'b1;
        tick();
        caprd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tmr = 32'd0; capin = 1'b1; capen = 1'b1;
        capedge = 2'b01; caprd = 1'b0; capovfclr = 1'b0;
        tick(); tick();
        vec_cnt++; if (capval !== 32'd0) begin err_cnt++; $display("FAIL reset_capval got %0d want 0", capval); end
        vec_cnt++; if (capvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_capvalid got %0b want 0", capvalid); end
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL reset_capcnt got %0d want 0", capcnt); end
        vec_cnt++; if (capovf !== 1'b0) begin err_cnt++; $display("FAIL reset_capovf got %0b want 0", capovf); end
    endtask

    task automatic test_warmup();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL warmup_cnt cyc %0d got %0d want 0", i, capcnt); end
        end
        capin = 1'b0;
        repeat (4) tick();
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL warmup_fall_ignored got %0d want 0", capcnt); end
    endtask

    task automatic test_latency();
        capedge = 2'b01;
        tmr = 32'd99;
        capin = 1'b1;
        tick(); tick();
        vec_cnt++; if (capvalid !== 1'b0) begin err_cnt++; $display("FAIL latency_early got %0b want 0", capvalid); end
        tick();
        vec_cnt++; if (capvalid !== 1'b1) begin err_cnt++; $display("FAIL latency_valid got %0b want 1", capvalid); end
        vec_cnt++; if (capval !== 32'd101) begin err_cnt++; $display("FAIL latency_capval got %0d want 101", capval); end
        vec_cnt++; if (capcnt !== 3'd1) begin err_cnt++; $display("FAIL latency_cnt got %0d want 1", capcnt); end
        pop();
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL latency_pop got %0d want 0", capcnt); end
        capin = 1'b0;
        repeat (4) tick();
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL latency_fall_ignored got %0d want 0", capcnt); end
    endtask

    task automatic test_both_edges();
        capedge = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_v[k] = tmr + 32'd2;
            capin = ~capin;
            repeat (5) tick();
        end
        vec_cnt++; if (capcnt !== 3'd4) begin err_cnt++; $display("FAIL both_cnt got %0d want 4", capcnt); end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++; if (capval !== exp_v[k]) begin err_cnt++; $display("FAIL both_val%0d got %0d want %0d", k, capval, exp_v[k]); end
            pop();
        end
        vec_cnt++; if (capvalid !== 1'b0) begin err_cnt++; $display("FAIL both_drained got %0b want 0", capvalid); end
    endtask

    task automatic test_falling_only();
        capedge = 2'b10;
        for (int k = 0; k < 4; k++) begin
            exp_v[k] = tmr + 32'd2;
            capin = ~capin;
            repeat (5) tick();
        end
        vec_cnt++; if (capcnt !== 3'd2) begin err_cnt++; $display("FAIL fall_cnt got %0d want 2", capcnt); end
        vec_cnt++; if (capval !== exp_v[1]) begin err_cnt++; $display("FAIL fall_val0 got %0d want %0d", capval, exp_v[1]); end
        pop();
        vec_cnt++; if (capval !== exp_v[3]) begin err_cnt++; $display("FAIL fall_val1 got %0d want %0d", capval, exp_v[3]); end
        pop();
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL fall_drained got %0d want 0", capcnt); end
    endtask

    task automatic test_back_to_back();
        capedge = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_v[k] = tmr + 32'd2;
            capin = ~capin;
            tick();
        end
        tick(); tick();
        vec_cnt++; if (capcnt !== 3'd4) begin err_cnt++; $display("FAIL b2b_cnt got %0d want 4", capcnt); end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++; if (capval !== exp_v[k]) begin err_cnt++; $display("FAIL b2b_val%0d got %0d want %0d", k, capval, exp_v[k]); end
            pop();
        end
    endtask

    task automatic test_overflow();
        capedge = 2'b11;
        for (int k = 0; k < 5; k++) begin
            exp_v[k] = tmr + 32'd2;
            capin = ~capin;
            repeat (3) tick();
        end
        vec_cnt++; if (capcnt !== 3'd4) begin err_cnt++; $display("FAIL ovf_cnt got %0d want 4", capcnt); end
        vec_cnt++; if (capovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got %0b want 1", capovf); end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++; if (capval !== exp_v[k]) begin err_cnt++; $display("FAIL ovf_val%0d got %0d want %0d", k, capval, exp_v[k]); end
            pop();
        end
        vec_cnt++; if (capovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky got %0b want 1", capovf); end
        capovfclr = 1'b1; tick(); capovfclr = 1'b0;
        vec_cnt++; if (capovf !== 1'b0) begin err_cnt++; $display("FAIL ovf_clear got %0b want 0", capovf); end
    endtask

    task automatic test_push_pop_full();
        for (int k = 0; k < 4; k++) begin
            exp_v[k] = tmr + 32'd2;
            capin = ~capin;
            repeat (3) tick();
        end
        exp_v[4] = tmr + 32'd2;
        capin = ~capin;
        tick(); tick();
        caprd = 1'b1; tick(); caprd = 1'b0;
        vec_cnt++; if (capcnt !== 3'd4) begin err_cnt++; $display("FAIL pp_cnt got %0d want 4", capcnt); end
        vec_cnt++; if (capovf !== 1'b0) begin err_cnt++; $display("FAIL pp_ovf got %0b want 0", capovf); end
        vec_cnt++; if (capval !== exp_v[1]) begin err_cnt++; $display("FAIL pp_head got %0d want %0d", capval, exp_v[1]); end
    endtask

    task automatic test_ovf_clr_race();
        capin = ~capin;
        tick(); tick();
        capovfclr = 1'b1; tick(); capovfclr = 1'b0;
        vec_cnt++; if (capovf !== 1'b1) begin err_cnt++; $display("FAIL race_set_wins got %0b want 1", capovf); end
        vec_cnt++; if (capcnt !== 3'd4) begin err_cnt++; $display("FAIL race_cnt got %0d want 4", capcnt); end
        capovfclr = 1'b1; tick(); capovfclr = 1'b0;
        vec_cnt++; if (capovf !== 1'b0) begin err_cnt++; $display("FAIL race_clear got %0b want 0", capovf); end
        for (int k = 1; k < 5; k++) begin
            vec_cnt++; if (capval !== exp_v[k]) begin err_cnt++; $display("FAIL race_val%0d got %0d want %0d", k, capval, exp_v[k]); end
            pop();
        end
    endtask

    task automatic test_enable();
        capen = 1'b0;
        capedge = 2'b11;
        for (int k = 0; k < 4; k++) begin
            capin = ~capin;
            repeat (3) tick();
        end
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL en_blocked got %0d want 0", capcnt); end
        capin = 1'b1;
        repeat (5) tick();
        capen = 1'b1;
        repeat (5) tick();
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL en_stale got %0d want 0", capcnt); end
    endtask

    task automatic test_pop_empty();
        pop();
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL empty_pop_cnt got %0d want 0", capcnt); end
        vec_cnt++; if (capval !== 32'd0) begin err_cnt++; $display("FAIL empty_capval got %0d want 0", capval); end
        exp_v[0] = tmr + 32'd2;
        capin = ~capin;
        repeat (3) tick();
        vec_cnt++; if (capcnt !== 3'd1) begin err_cnt++; $display("FAIL empty_then_push got %0d want 1", capcnt); end
        vec_cnt++; if (capval !== exp_v[0]) begin err_cnt++; $display("FAIL empty_then_val got %0d want %0d", capval, exp_v[0]); end
        pop();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            capin = ~capin;
            repeat (3) tick();
        end
        vec_cnt++; if (capcnt !== 3'd2) begin err_cnt++; $display("FAIL mid_fill got %0d want 2", capcnt); end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL mid_rst_cnt got %0d want 0", capcnt); end
        vec_cnt++; if (capvalid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_valid got %0b want 0", capvalid); end
        vec_cnt++; if (capval !== 32'd0) begin err_cnt++; $display("FAIL mid_rst_val got %0d want 0", capval); end
        vec_cnt++; if (capovf !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_ovf got %0b want 0", capovf); end
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        vec_cnt++; if (capcnt !== 3'd0) begin err_cnt++; $display("FAIL mid_after_release got %0d want 0", capcnt); end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_latency();
        test_both_edges();
        test_falling_only();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_ovf_clr_race();
        test_enable();
        test_pop_empty();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/tmr_capture.md
# tmr_capture

Input-capture stage downstream of the 32-bit timer: it consumes the free-running timer count `TMR` and records its value whenever a selected edge occurs on an asynchronous external pin. Captured values are queued in a small FIFO that software or a bus wrapper drains one entry at a time. An overflow flag reports events lost to a full queue. The block sits between the timer core and the peripheral register interface.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, 2: synchronizer flops on `CAPIN`; at least 2.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `TMR`  in  32  current timer count from the timer core.
- `CAPIN`  in  1  asynchronous external capture pin.
- `CAPEN`  in  1  capture enable.
- `CAPEDGE`  in  2  edge select: 00 none, 01 rising, 10 falling, 11 both.
- `CAPRD`  in  1  pop the head entry; single-cycle pulse.
- `CAPOVFCLR`  in  1  clear `CAPOVF`.
- `CAPVAL`  out  32  head-of-FIFO captured value; 0 when empty.
- `CAPVALID`  out  1  FIFO non-empty.
- `CAPCNT`  out  log2(DEPTH)+1  number of stored entries.
- `CAPOVF`  out  1  sticky overflow flag: a capture was dropped.

## Operation
- Synchronizer: `CAPIN` passes through `SYNC_STAGES` flops, then one history flop. All reset to 0.
- Warm-up: a counter holds off edge detection for `SYNC_STAGES`+1 cycles after reset release. This prevents a pin that is high at reset from producing a false rising edge.
- Edge detection compares the last synchronizer stage (`s`) with the history flop (`h`).
  - Rising edge: `s`=1 and `h`=0.
  - Falling edge: `s`=0 and `h`=1.
- An event is a detected edge matching `CAPEDGE` while `CAPEN`=1 and warm-up is complete.
- Synchronizer and history flops run regardless of `CAPEN`. Enabling capture therefore never produces a stale edge.
- On an event, the `TMR` value present in that cycle is pushed into the FIFO.
- FIFO: circular buffer with read and write pointers of log2(DEPTH)+1 bits. Pointers wrap modulo 2·DEPTH.
  - Full: pointer MSBs differ and all lower bits are equal.
  - Empty: pointers are equal.
- Pop: `CAPRD`=1 with FIFO non-empty advances the read pointer. `CAPRD` when empty is ignored; no pointer change.
- Push when not full: the entry is stored.
- Push when full without a pop: the new value is dropped and `CAPOVF` is set. Existing contents are untouched.
- Push and pop in the same cycle: both take effect, including when full. `CAPCNT` is unchanged and no overflow is raised.
- `CAPOVF` is set by a drop and cleared by `CAPOVFCLR`. If both occur in the same cycle, set wins.
- `CAPEN`=0 blocks new captures only. FIFO contents, `CAPOVF` and pops are unaffected.
- `CAPEDGE` changes take effect on the next cycle's detection. There is no retroactive capture.

## Timing
- Reset values: `CAPVAL`=0, `CAPVALID`=0, `CAPCNT`=0, `CAPOVF`=0. Pointers, warm-up counter, synchronizer and history flops are all 0.
- Capture latency (`SYNC_STAGES`=2): `CAPIN` toggles before clock edge n.
  - Edge is detected in the cycle after edge n+1.
  - Push occurs at edge n+2, storing the `TMR` value held between edges n+1 and n+2.
  - `CAPVALID` and `CAPCNT` update after edge n+2.
- General latency: push at edge n+`SYNC_STAGES`.
- Pulse width: `CAPIN` pulses shorter than one clock period may be missed. Each stable level must last at least 1 cycle to be seen.
- Both-edge mode: back-to-back toggles on consecutive cycles produce one push per cycle.
- `CAPVAL` is combinational from FIFO storage at the read pointer. It updates in the cycle after a pop.
- `CAPCNT` and `CAPVALID` are registered-pointer derived and update after the clock edge of a push or pop.
- `CAPOVF` updates after the edge of the dropping push.
- Reset mid-operation: all state clears immediately. Warm-up restarts, and stored entries are lost.

## Test plan
- Reset release with `CAPIN` held 1, `CAPEDGE`=01, `CAPEN`=1 -> no push; `CAPCNT`=0 for 20 cycles.
- `TMR` incrementing by 1 each cycle; `CAPIN` rises before edge where `TMR` becomes 100 -> `CAPVAL`=101 and `CAPVALID`=1 two edges later.
- `CAPEDGE`=11; drive 4 pin toggles spaced 5 cycles -> 4 entries, spaced by 5, popped in order.
  - Falling-only mode (10) with the same stimulus -> 2 entries.
- Fill FIFO (`DEPTH`=4), then one more edge -> `CAPCNT`=4 and `CAPOVF`=1, with the first 4 values intact.
  - Repeat with `CAPRD` asserted in the same cycle as the 5th push -> no overflow; the oldest value is popped and the newest is stored.
- `CAPOVFCLR` pulsed in the same cycle as a dropping push -> `CAPOVF` stays 1. The next `CAPOVFCLR` alone clears it.
- `CAPEN`=0 during edges -> no pushes. Enable while pin is stable -> no capture. `CAPRD` on empty FIFO -> `CAPCNT` stays 0. Assert `rst_n` low mid-fill -> all outputs return to 0.
